npc_mem_arb: RTL and testbench

Two-requester memory arbiter for the NPC core. It shares one downstream memory port between the instruction-fetch requester (read only) and the load/store requester (read/write). Arbitration is round-robin. The block holds at most one transaction in flight and enforces a response timeout. It sits between the core's fetch/LSU logic and the single memory/bus interface.

---
 rtl/npc_mem_arb.sv | 154 +++++++++++++++
 tb/tb_npc_mem_arb.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/npc_mem_arb.sv
// Round-robin arbiter sharing one memory port between fetch and load/store, one transaction in flight.
// Min latency accept->resp_valid is 3 cycles; mem_req holds until mem_req_ready, resp pulses have no backpressure.
module npc_mem_arb #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic                clk,
  input  logic                global_rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic                ls_we,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wstrb,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ls_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_err,
  output logic                busy
);

  localparam int   STRB_W = DATA_W / 8;
  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_LS = 1'b1;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t              state, state_nxt;
  logic                last_grant, owner;
  logic [ADDR_W-1:0]   hold_addr;
  logic                hold_we;
  logic [DATA_W-1:0]   hold_wdata;
  logic [STRB_W-1:0]   hold_wstrb;
  logic [TO_W-1:0]     cnt;
  logic                grant_ls, grant_if, accept, complete, timeout_hit;
  logic [DATA_W-1:0]   resp_rdata;
  logic                resp_err;

  // On contention the requester that did not win last time gets the grant.
  assign grant_ls    = ls_req_valid && (!if_req_valid || (last_grant == GNT_IF));
  assign grant_if    = if_req_valid && !grant_ls;
  assign accept      = (state == IDLE) && (grant_ls || grant_if);
  assign complete    = (state == RESP) && mem_resp_valid;
  assign timeout_hit = (state != IDLE) && (cnt == TO_W'(TIMEOUT)) && !complete;

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = REQ;
      REQ:     if (timeout_hit) state_nxt = IDLE;
               else if (mem_req_ready) state_nxt = RESP;
      RESP:    if (complete || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    if_req_ready  = (state == IDLE) && grant_if;
    ls_req_ready  = (state == IDLE) && grant_ls;
    mem_req_valid = (state == REQ);
    busy          = (state != IDLE);
  end

  assign mem_addr  = hold_addr;
  assign mem_we    = hold_we;
  assign mem_wdata = hold_wdata;
  assign mem_wstrb = hold_wstrb;

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      last_grant <= GNT_IF;
      owner      <= GNT_IF;
      hold_addr  <= '0;
      hold_we    <= 1'b0;
      hold_wdata <= '0;
      hold_wstrb <= '0;
      cnt        <= '0;
    end else if (accept) begin
      owner      <= grant_ls ? GNT_LS : GNT_IF;
      last_grant <= grant_ls ? GNT_LS : GNT_IF;
      cnt        <= '0;
      if (grant_ls) begin
        hold_addr  <= ls_addr;
        hold_we    <= ls_we;
        hold_wdata <= ls_wdata;
        hold_wstrb <= ls_we ? ls_wstrb : '0;
      end else begin
        hold_addr  <= if_addr;
        hold_we    <= 1'b0;
        hold_wdata <= '0;
        hold_wstrb <= '0;
      end
    end else if (state != IDLE) begin
      cnt <= cnt + TO_W'(1);
    end
  end

  // Writes and aborted transactions return zero data.
  always_comb begin
    resp_rdata = '0;
    resp_err   = 1'b1;
    if (complete) begin
      resp_rdata = hold_we ? '0 : mem_rdata;
      resp_err   = mem_err;
    end
  end

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      if_resp_valid <= 1'b0;
      if_rdata      <= '0;
      if_err        <= 1'b0;
      ls_resp_valid <= 1'b0;
      ls_rdata      <= '0;
      ls_err        <= 1'b0;
    end else begin
      if_resp_valid <= 1'b0;
      ls_resp_valid <= 1'b0;
      if (complete || timeout_hit) begin
        if (owner == GNT_LS) begin
          ls_resp_valid <= 1'b1;
          ls_rdata      <= resp_rdata;
          ls_err        <= resp_err;
        end else begin
          if_resp_valid <= 1'b1;
          if_rdata      <= resp_rdata;
          if_err        <= resp_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_npc_mem_arb.sv
// Directed bench for npc_mem_arb built with TIMEOUT=4 so the abort and the completion/timeout tie are reachable.
module tb_npc_mem_arb;

  logic        clk = 1'b0;
  logic        global_rst;
  logic        if_req_valid, if_req_ready, if_resp_valid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req_valid, ls_req_ready, ls_we, ls_resp_valid, ls_err;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [3:0]  ls_wstrb;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_resp_valid, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        busy;

  int checks = 0;
  int errors = 0;

  npc_mem_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .global_rst(global_rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_rdata(if_rdata), .if_err(if_err),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_we(ls_we), .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb),
    .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".if_rdy"}, if_req_ready, 0);
    check({tag, ".ls_rdy"}, ls_req_ready, 0);
    check({tag, ".if_rv"}, if_resp_valid, 0);
    check({tag, ".ls_rv"}, ls_resp_valid, 0);
    check({tag, ".rdata"}, {if_rdata, ls_rdata}, 0);
    check({tag, ".err"}, {if_err, ls_err}, 0);
    check({tag, ".mem_v"}, mem_req_valid, 0);
    check({tag, ".mem_f"}, {mem_addr, mem_we, mem_wstrb}, 0);
    check({tag, ".mem_wd"}, mem_wdata, 0);
    check({tag, ".busy"}, busy, 0);
  endtask

  initial begin
    global_rst = 1'b1;
    if_req_valid = 0; if_addr = 0;
    ls_req_valid = 0; ls_addr = 0; ls_we = 0; ls_wdata = 0; ls_wstrb = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0; mem_err = 0;
    #1;
    check_all_zero("rst");
    #12 global_rst = 1'b0;

    // Single fetch at minimum latency
    step;
    if_req_valid = 1; if_addr = 32'h8000_0000; mem_req_ready = 1;
    #1;
    check("f.if_rdy", if_req_ready, 1);
    check("f.ls_rdy", ls_req_ready, 0);
    step;
    if_req_valid = 0;
    #1;
    check("f.mem_v", mem_req_valid, 1);
    check("f.mem_addr", mem_addr, 32'h8000_0000);
    check("f.mem_we_strb_wd", {mem_we, mem_wstrb, mem_wdata}, 0);
    check("f.busy", busy, 1);
    step;
    mem_resp_valid = 1; mem_rdata = 32'h0010_0073; mem_err = 0;
    #1;
    check("f.mem_v_resp", mem_req_valid, 0);
    check("f.rv_early", if_resp_valid, 0);
    step;
    mem_resp_valid = 0;
    #1;
    check("f.if_rv", if_resp_valid, 1);
    check("f.if_rdata", if_rdata, 32'h0010_0073);
    check("f.if_err", if_err, 0);
    check("f.ls_rv", ls_resp_valid, 0);
    check("f.busy_idle", busy, 0);
    step;
    check("f.pulse", if_resp_valid, 0);
    check("f.hold", if_rdata, 32'h0010_0073);

    // Contention from reset: LS, IF, LS, IF
    global_rst = 1; #1 global_rst = 0;
    if_req_valid = 1; ls_req_valid = 1; ls_we = 0; ls_wstrb = 4'hF;
    if_addr = 32'h8000_0400; ls_addr = 32'h8000_0500; mem_req_ready = 1;
    for (int i = 0; i < 4; i++) begin
      automatic logic exp_ls = (i % 2 == 0);
      #1;
      check($sformatf("c%0d.ls_rdy", i), ls_req_ready, exp_ls);
      check($sformatf("c%0d.if_rdy", i), if_req_ready, !exp_ls);
      step;
      check($sformatf("c%0d.mem_addr", i), mem_addr, exp_ls ? 32'h8000_0500 : 32'h8000_0400);
      check($sformatf("c%0d.mem_wstrb", i), mem_wstrb, 0);
      step;
      mem_resp_valid = 1; mem_rdata = 32'h100 + i;
      step;
      mem_resp_valid = 0;
      #1;
      check($sformatf("c%0d.ls_rv", i), ls_resp_valid, exp_ls);
      check($sformatf("c%0d.if_rv", i), if_resp_valid, !exp_ls);
      if (exp_ls) check($sformatf("c%0d.ls_rdata", i), ls_rdata, 32'h100 + i);
      else        check($sformatf("c%0d.if_rdata", i), if_rdata, 32'h100 + i);
    end
    if_req_valid = 0; ls_req_valid = 0;

    // Store: write data passes through, read data is zeroed
    step;
    ls_req_valid = 1; ls_we = 1; ls_addr = 32'h8000_0100; ls_wdata = 32'hDEAD_BEEF; ls_wstrb = 4'b0011;
    #1;
    check("s.ls_rdy", ls_req_ready, 1);
    step;
    ls_req_valid = 0;
    #1;
    check("s.mem_v", mem_req_valid, 1);
    check("s.mem_we", mem_we, 1);
    check("s.mem_addr", mem_addr, 32'h8000_0100);
    check("s.mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("s.mem_wstrb", mem_wstrb, 4'b0011);
    step;
    mem_resp_valid = 1; mem_rdata = 32'h1234_5678; mem_err = 0;
    step;
    mem_resp_valid = 0;
    #1;
    check("s.ls_rv", ls_resp_valid, 1);
    check("s.ls_rdata", ls_rdata, 0);
    check("s.ls_err", ls_err, 0);
    check("s.if_rv", if_resp_valid, 0);

    // Backpressure for 3 cycles, then completion lands on the timeout cycle
    ls_we = 0;
    if_req_valid = 1; if_addr = 32'h8000_0200; mem_req_ready = 0;
    #1;
    check("b.if_rdy", if_req_ready, 1);
    for (int c = 1; c <= 3; c++) begin
      step;
      if_req_valid = 1; ls_req_valid = 1;
      if_addr = $urandom; ls_addr = $urandom; ls_wdata = $urandom;
      #1;
      check($sformatf("b%0d.mem_v", c), mem_req_valid, 1);
      check($sformatf("b%0d.mem_addr", c), mem_addr, 32'h8000_0200);
      check($sformatf("b%0d.mem_we_strb_wd", c), {mem_we, mem_wstrb, mem_wdata}, 0);
      check($sformatf("b%0d.rdy", c), {if_req_ready, ls_req_ready}, 0);
      check($sformatf("b%0d.busy", c), busy, 1);
    end
    step;
    if_req_valid = 0; ls_req_valid = 0; mem_req_ready = 1;
    #1;
    check("b4.mem_v", mem_req_valid, 1);
    step;
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'hCAFE_F00D; mem_err = 1;
    #1;
    check("b5.busy", busy, 1);
    step;
    mem_resp_valid = 0; mem_err = 0;
    #1;
    check("tie.if_rv", if_resp_valid, 1);
    check("tie.if_rdata", if_rdata, 32'hCAFE_F00D);
    check("tie.if_err", if_err, 1);
    check("tie.busy", busy, 0);

    // Timeout: memory never accepts
    if_req_valid = 1; if_addr = 32'h8000_0300;
    #1;
    check("t0.if_rdy", if_req_ready, 1);
    for (int c = 1; c <= 5; c++) begin
      step;
      if_req_valid = 0;
      #1;
      check($sformatf("t%0d.busy", c), busy, 1);
      check($sformatf("t%0d.if_rv", c), if_resp_valid, 0);
    end
    step;
    check("t6.if_rv", if_resp_valid, 1);
    check("t6.if_err", if_err, 1);
    check("t6.if_rdata", if_rdata, 0);
    check("t6.mem_v", mem_req_valid, 0);
    check("t6.busy", busy, 0);
    mem_resp_valid = 1; mem_rdata = 32'h55;
    step;
    mem_resp_valid = 0;
    check("stray.rv", {if_resp_valid, ls_resp_valid}, 0);
    check("stray.if_rdata", if_rdata, 0);
    check("stray.busy", busy, 0);

    // Reset while in RESP after an LS grant
    ls_req_valid = 1; ls_we = 0; ls_addr = 32'h8000_0600; mem_req_ready = 1;
    #1;
    check("r.ls_rdy", ls_req_ready, 1);
    step;
    ls_req_valid = 0;
    step;
    check("r.busy_resp", busy, 1);
    global_rst = 1;
    #1;
    check_all_zero("r.async");
    #3 global_rst = 0;
    mem_resp_valid = 1; mem_rdata = 32'h77;
    for (int c = 0; c < 2; c++) begin
      step;
      check($sformatf("r%0d.no_rv", c), {if_resp_valid, ls_resp_valid}, 0);
    end
    mem_resp_valid = 0;
    if_req_valid = 1; ls_req_valid = 1;
    #1;
    check("r.gnt_ls", ls_req_ready, 1);
    check("r.gnt_if", if_req_ready, 0);
    if_req_valid = 0; ls_req_valid = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
